// File: rtl/tmds_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_pkg : shared TMDS control tokens, disparity width, helpers       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package tmds_pkg;

   localparam int CNT_W = 5;

   localparam logic [9:0] TOKEN_00    = 10'b1101010100;
   localparam logic [9:0] TOKEN_01    = 10'b0010101011;
   localparam logic [9:0] TOKEN_10    = 10'b0101010100;
   localparam logic [9:0] TOKEN_11    = 10'b1010101011;
   localparam logic [9:0] RESET_TOKEN = TOKEN_00;

   function automatic logic [9:0] ctrl_token(input logic [1:0] ctrl);
      logic [9:0] t;
      case (ctrl)
         2'b00:   t = TOKEN_00;
         2'b01:   t = TOKEN_01;
         2'b10:   t = TOKEN_10;
         default: t = TOKEN_11;
      endcase
      return t;
   endfunction

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_channel : one DVI 1.0 TMDS 8b/10b encoder lane, 2-stage pipe     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tmds_channel
   import tmds_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       de,
   input  logic [1:0] ctrl,
   input  logic [7:0] d,
   output logic [9:0] q
);

   logic [8:0]              qm_d, qm_q;
   logic [3:0]              n1_d, n1_q;
   logic [3:0]              n0_d, n0_q;
   logic                    de_d, de_q;
   logic [1:0]              ctrl_d, ctrl_q;
   logic [9:0]              sym_d, sym_q;
   logic signed [CNT_W-1:0] cnt_d, cnt_q;
   logic signed [CNT_W-1:0] diff;
   logic [3:0]              n1_in;
   logic                    use_xnor;

   // Stage 1: transition minimisation
   always_comb begin
      n1_in    = popcount8(d);
      use_xnor = (n1_in > 4'd4) || ((n1_in == 4'd4) && !d[0]);
      qm_d     = '0;
      qm_d[0]  = d[0];
      for (int i = 1; i < 8; i++) begin
         qm_d[i] = use_xnor ? ~(qm_d[i-1] ^ d[i]) : (qm_d[i-1] ^ d[i]);
      end
      qm_d[8] = ~use_xnor;
      n1_d    = popcount8(qm_d[7:0]);
      n0_d    = 4'd8 - n1_d;
      de_d    = de;
      ctrl_d  = ctrl;
   end

   // Stage 2: DC balance against the running disparity
   always_comb begin
      diff  = $signed({1'b0, n1_q}) - $signed({1'b0, n0_q});
      sym_d = sym_q;
      cnt_d = cnt_q;
      if (!de_q) begin
         sym_d = ctrl_token(ctrl_q);
         cnt_d = '0;
      end else if ((cnt_q == 5'sd0) || (n1_q == n0_q)) begin
         sym_d = {~qm_q[8], qm_q[8], qm_q[8] ? qm_q[7:0] : ~qm_q[7:0]};
         cnt_d = qm_q[8] ? (cnt_q + diff) : (cnt_q - diff);
      end else if (((cnt_q > 5'sd0) && (n1_q > n0_q)) ||
                   ((cnt_q < 5'sd0) && (n0_q > n1_q))) begin
         sym_d = {1'b1, qm_q[8], ~qm_q[7:0]};
         cnt_d = cnt_q + (qm_q[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         sym_d = {1'b0, qm_q[8], qm_q[7:0]};
         cnt_d = cnt_q - (qm_q[8] ? 5'sd0 : 5'sd2) + diff;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         qm_q   <= '0;
         n1_q   <= '0;
         n0_q   <= '0;
         de_q   <= 1'b0;
         ctrl_q <= 2'b00;
         sym_q  <= RESET_TOKEN;
         cnt_q  <= '0;
      end else begin
         qm_q   <= qm_d;
         n1_q   <= n1_d;
         n0_q   <= n0_d;
         de_q   <= de_d;
         ctrl_q <= ctrl_d;
         sym_q  <= sym_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q = sym_q;

endmodule
`default_nettype wire

// File: rtl/tmds_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tmds_encoder : three-lane DVI TMDS encoder, sync carried on lane 0    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tmds_encoder
   import tmds_pkg::*;
(
   input  logic       clk_pix,
   input  logic       rst_pix,
   input  logic       de,
   input  logic       hsync,
   input  logic       vsync,
   input  logic [7:0] r,
   input  logic [7:0] g,
   input  logic [7:0] b,
   output logic [9:0] tmds_b,
   output logic [9:0] tmds_g,
   output logic [9:0] tmds_r
);

   tmds_channel u_ch0_b (
      .clk  (clk_pix),
      .rst  (rst_pix),
      .de   (de),
      .ctrl ({vsync, hsync}),
      .d    (b),
      .q    (tmds_b)
   );

   tmds_channel u_ch1_g (
      .clk  (clk_pix),
      .rst  (rst_pix),
      .de   (de),
      .ctrl (2'b00),
      .d    (g),
      .q    (tmds_g)
   );

   tmds_channel u_ch2_r (
      .clk  (clk_pix),
      .rst  (rst_pix),
      .de   (de),
      .ctrl (2'b00),
      .d    (r),
      .q    (tmds_r)
   );

endmodule
`default_nettype wire

// File: tb/tb_tmds_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tmds_encoder : directed and randomized checks of tmds_encoder      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_tmds_encoder;

   logic       clk_pix = 1'b0;
   logic       rst_pix;
   logic       de;
   logic       hsync;
   logic       vsync;
   logic [7:0] r, g, b;
   logic [9:0] tmds_b, tmds_g, tmds_r;

   int checks = 0;
   int errors = 0;

   localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

   typedef struct {
      logic [9:0] sb, sg, sr;
      logic       de;
      logic [7:0] r, g, b;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   cnt_m[3];

   tmds_encoder dut (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .de      (de),
      .hsync   (hsync),
      .vsync   (vsync),
      .r       (r),
      .g       (g),
      .b       (b),
      .tmds_b  (tmds_b),
      .tmds_g  (tmds_g),
      .tmds_r  (tmds_r)
   );

   always #5 clk_pix = ~clk_pix;

   // Reference encoder: the disparity counter is tracked as the true
   // ones-minus-zeros balance of every emitted symbol since blanking.
   task automatic model_encode(input logic [7:0] d, input logic den, input logic [1:0] c,
                               input int cnt_in, output logic [9:0] sym, output int cnt_out);
      int         ones_d, ones_q;
      logic       xn, qm8, inv;
      logic [7:0] qm;
      ones_d = $countones(d);
      xn     = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
      qm[0]  = d[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm8    = ~xn;
      ones_q = $countones(qm);
      if (!den) begin
         sym     = TOK[c];
         cnt_out = 0;
      end else begin
         if (cnt_in == 0 || ones_q == 4)                                  inv = ~qm8;
         else if ((cnt_in > 0 && ones_q > 4) || (cnt_in < 0 && ones_q < 4)) inv = 1'b1;
         else                                                              inv = 1'b0;
         sym     = {inv, qm8, inv ? ~qm : qm};
         cnt_out = cnt_in + 2 * $countones(sym) - 10;
      end
   endtask

   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] v, dd;
      v     = s[9] ? ~s[7:0] : s[7:0];
      dd[0] = v[0];
      for (int i = 1; i < 8; i++) dd[i] = s[8] ? (v[i] ^ v[i-1]) : ~(v[i] ^ v[i-1]);
      return dd;
   endfunction

   // Applies one pixel, advances one clock; cur then holds the expected
   // symbols for what the outputs show after that edge.
   task automatic drive(input logic rst_i, input logic de_i, input logic hs_i, input logic vs_i,
                        input logic [7:0] r_i, input logic [7:0] g_i, input logic [7:0] b_i);
      exp_t e;
      int   nc;
      rst_pix = rst_i; de = de_i; hsync = hs_i; vsync = vs_i;
      r = r_i; g = g_i; b = b_i;
      if (rst_i) begin
         cnt_m = '{0, 0, 0};
         e.sb = TOK[0]; e.sg = TOK[0]; e.sr = TOK[0];
         e.de = 1'b0; e.r = 8'h00; e.g = 8'h00; e.b = 8'h00;
         exp_q.delete();
         exp_q.push_back(e);
         exp_q.push_back(e);
      end else begin
         model_encode(b_i, de_i, {vs_i, hs_i}, cnt_m[0], e.sb, nc); cnt_m[0] = nc;
         model_encode(g_i, de_i, 2'b00,        cnt_m[1], e.sg, nc); cnt_m[1] = nc;
         model_encode(r_i, de_i, 2'b00,        cnt_m[2], e.sr, nc); cnt_m[2] = nc;
         e.de = de_i; e.r = r_i; e.g = g_i; e.b = b_i;
         exp_q.push_back(e);
      end
      @(posedge clk_pix);
      #1;
      cur = exp_q.pop_front();
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         checks++;
         if (tmds_b !== TOK[0] || tmds_g !== TOK[0] || tmds_r !== TOK[0]) begin
            errors++;
            $display("FAIL reset_hold cyc=%0d got b=%h g=%h r=%h want all %h", i, tmds_b, tmds_g, tmds_r, TOK[0]);
         end
      end
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
         checks++;
         if (tmds_b !== TOK[0] || tmds_g !== TOK[0] || tmds_r !== TOK[0]) begin
            errors++;
            $display("FAIL reset_release cyc=%0d got b=%h g=%h r=%h want all %h", i, tmds_b, tmds_g, tmds_r, TOK[0]);
         end
      end
   endtask

   task automatic test_ctrl_tokens();
      logic [1:0] c;
      for (int j = 0; j < 5; j++) begin
         c = (j < 4) ? 2'(j) : 2'b00;
         drive(1'b0, 1'b0, c[0], c[1], 8'($urandom), 8'($urandom), 8'($urandom));
         if (j > 0) begin
            checks++;
            if (tmds_b !== TOK[j-1] || tmds_g !== TOK[0] || tmds_r !== TOK[0]) begin
               errors++;
               $display("FAIL ctrl_token ctrl=%0d got b=%h g=%h r=%h want b=%h g=r=%h",
                        j - 1, tmds_b, tmds_g, tmds_r, TOK[j-1], TOK[0]);
            end
         end
      end
   endtask

   task automatic test_zeros();
      logic [9:0] want [3];
      want = '{10'h100, 10'h3FF, 10'h100};
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'h00);
         if (i > 0) begin
            checks++;
            if (tmds_b !== want[i-1]) begin
               errors++;
               $display("FAIL zeros_disparity px=%0d got %h want %h", i - 1, tmds_b, want[i-1]);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== want[2]) begin
         errors++;
         $display("FAIL zeros_disparity px=2 got %h want %h", tmds_b, want[2]);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== TOK[0]) begin
         errors++;
         $display("FAIL zeros_to_blank got %h want %h", tmds_b, TOK[0]);
      end
   endtask

   task automatic test_ones();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'hFF);
      checks++;
      if (tmds_b !== 10'h200) begin
         errors++;
         $display("FAIL ones_disparity px=0 got %h want %h", tmds_b, 10'h200);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== 10'h0FF) begin
         errors++;
         $display("FAIL ones_disparity px=1 got %h want %h", tmds_b, 10'h0FF);
      end
   endtask

   task automatic test_reset_midline();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== TOK[0] || tmds_g !== TOK[0] || tmds_r !== TOK[0]) begin
         errors++;
         $display("FAIL midline_reset got b=%h g=%h r=%h want all %h", tmds_b, tmds_g, tmds_r, TOK[0]);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== TOK[0]) begin
         errors++;
         $display("FAIL midline_flush got %h want %h", tmds_b, TOK[0]);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== 10'h100) begin
         errors++;
         $display("FAIL midline_resume px=0 got %h want %h", tmds_b, 10'h100);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      checks++;
      if (tmds_b !== 10'h3FF) begin
         errors++;
         $display("FAIL midline_resume px=1 got %h want %h", tmds_b, 10'h3FF);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic test_random_soak();
      int         disp [3];
      logic [9:0] sym_a [3];
      logic [7:0] dat_a [3];
      logic       den;
      int         shown;
      shown = 0;
      disp  = '{0, 0, 0};
      for (int i = 0; i < 30000; i++) begin
         den = ((i % 250) < 200) && ($urandom_range(0, 63) != 0);
         drive(1'b0, den, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
         checks++;
         if (tmds_b !== cur.sb || tmds_g !== cur.sg || tmds_r !== cur.sr) begin
            errors++;
            if (shown < 20) begin
               shown++;
               $display("FAIL soak_symbol i=%0d got b=%h g=%h r=%h want b=%h g=%h r=%h",
                        i, tmds_b, tmds_g, tmds_r, cur.sb, cur.sg, cur.sr);
            end
         end
         if (cur.de) begin
            sym_a = '{tmds_b, tmds_g, tmds_r};
            dat_a = '{cur.b, cur.g, cur.r};
            for (int ch = 0; ch < 3; ch++) begin
               disp[ch] = disp[ch] + 2 * $countones(sym_a[ch]) - 10;
               checks++;
               if (decode(sym_a[ch]) !== dat_a[ch]) begin
                  errors++;
                  if (shown < 20) begin
                     shown++;
                     $display("FAIL soak_decode i=%0d ch=%0d got %h want %h", i, ch, decode(sym_a[ch]), dat_a[ch]);
                  end
               end
               checks++;
               if (disp[ch] > 10 || disp[ch] < -10) begin
                  errors++;
                  if (shown < 20) begin
                     shown++;
                     $display("FAIL soak_disparity i=%0d ch=%0d got %0d want within +/-10", i, ch, disp[ch]);
                  end
               end
            end
         end else begin
            disp = '{0, 0, 0};
         end
      end
   endtask

   initial begin
      cur.sb = TOK[0]; cur.sg = TOK[0]; cur.sr = TOK[0];
      cur.de = 1'b0; cur.r = 8'h00; cur.g = 8'h00; cur.b = 8'h00;
      exp_q.push_back(cur);
      cnt_m = '{0, 0, 0};
      test_reset();
      test_ctrl_tokens();
      test_zeros();
      test_ones();
      test_reset_midline();
      test_random_soak();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
